interrupt_controller: RTL
=========================

// Module: interrupt_controller
// PURPOSE
//  Programmable interrupt controller directly upstream of the multi-cycle cpu.
//  Collects NUM_IRQ device requests and one NMI source; latches, masks and prioritises them.
//  Drives the cpu's INT/NMI request lines with a stable vector address, and sequences the
//  ack / end-of-interrupt handshake so only one maskable interrupt is in service at a time.
// PARAMETERS
//  NUM_IRQ   8      number of maskable request lines; index 0 = highest priority
//  VEC_BASE  28     vector address of irq 0; irq i vectors to VEC_BASE+i
//  NMI_VEC   27     vector address presented with nmi_req
// PORTS
//  clk         in   1        single clock, all state on posedge
//  rst_n       in   1        asynchronous, active-low reset
//  irq_in      in   NUM_IRQ  device requests
//  nmi_in      in   1        non-maskable source
//  int_disable in   1        global mask from cpu (INT_Disable)
//  mask_we     in   1        1-cycle write strobe for mask register
//  mask_wdata  in   NUM_IRQ  new mask; bit=1 blocks that irq
//  int_ack     in   1        1-cycle pulse from cpu: INT taken (INA)
//  nmi_ack     in   1        1-cycle pulse from cpu: NMI taken
//  eoi         in   1        1-cycle pulse from cpu: end of current maskable ISR
//  int_req     out  1        to cpu INT
//  nmi_req     out  1        to cpu NMI
//  int_vector  out  32       VEC_BASE+active_id while int_req/in service, else 0
//  nmi_vector  out  32       constant NMI_VEC
//  pending     out  NUM_IRQ  pending register (status)
//  in_service  out  NUM_IRQ  one-hot id of ISR in progress, or 0
// BEHAVIOUR
//  Reset (async, rst_n=0): pending=0, mask=0 (all enabled), state=IDLE, int_req=0, nmi_req=0,
//   int_vector=0, in_service=0, active_id=0. Reset mid-handshake aborts it; nothing is kept.
//  Pending: pending[i] set at edge where irq_in[i] is sampled high (level mode) or rising (edge mode).
//   Cleared only at int_ack for active_id. Set and clear in the same cycle: set wins.
//  eligible = pending & ~mask & ~in_service; winner = lowest set index (combinational).
//  FSM (registered outputs; int_req is 1 only in REQ):
//   IDLE  : eligible!=0 & !int_disable -> latch active_id=winner -> REQ.
//   REQ   : int_vector stable. int_ack -> clear pending[active_id], set in_service -> INSERV.
//           int_disable=1 or mask bit of active_id set -> IDLE, pending kept (request withdrawn).
//           Higher-priority arrival does NOT preempt; id stays frozen until ack or withdrawal.
//   INSERV: int_req=0; wait for eoi -> clear in_service -> IDLE. New requests only latch.
//   int_ack outside REQ and eoi outside INSERV are ignored.
//  Latency: irq high sampled at edge k -> pending at k -> REQ and int_req=1 after edge k+1.
//   Back-to-back: eoi at edge m with another eligible -> int_req=1 after edge m+1.
//  NMI: rising nmi_in sets nmi_req (next edge); cleared by nmi_ack; rise+ack same cycle -> stays 1.
//   Ignores mask, int_disable and FSM state. While nmi_req=1, int_req is forced 0 (FSM holds REQ).
//  mask_we takes effect next cycle; masking a pending bit keeps it pending.
// CONFIGURATION
//  IRQ_EDGE_EN defined: irq_in edge-triggered: per-line delay flop (reset 0), pending set on 0->1 only;
//   holding a line high yields exactly one interrupt.
//  IRQ_EDGE_EN undefined: level-triggered: pending re-sets each cycle the line is high, so a
//   line still high at int_ack re-requests after eoi. NMI is always edge-triggered.
// STRUCTURE
//  intc_defs package/include: FSM state encodings (IDLE/REQ/INSERV), VEC_BASE/NMI_VEC defaults,
//   ID width = $clog2(NUM_IRQ).
//  One sub-module: intc_prio_enc (NUM_IRQ-bit vector -> valid + lowest-index id), purely combinational.
// TESTING
//  1 irq_in=8'h04 one cycle (edge mode) -> int_req=1 two edges later, int_vector=30; int_ack -> int_req=0,
//    pending=0, in_service=8'h04; eoi -> in_service=0, no further int_req.
//  2 irq_in=8'h82 same cycle -> vector 29 first; after ack+eoi -> vector 35; pending=0 at end.
//  3 mask_wdata=8'h01, irq 0 and 3 raised -> only vector 31 served; unmask -> vector 28 served.
//  4 In REQ raise nmi_in -> nmi_req=1, int_req=0; nmi_ack -> int_req=1 again, vector unchanged.
//  5 In REQ set int_disable=1 -> IDLE, int_req=0, pending kept; clear -> re-request same vector.
//  6 rst_n=0 asserted in INSERV, asynchronously between edges -> all outputs 0 immediately;
//    level mode, line held high -> re-request after reset release.

Source files
------------

// File: rtl/intc_defs_pkg.sv
// Shared definitions for the interrupt controller.
//  - FSM state encoding (IDLE / REQ / INSERV)
//  - default parameter values (NUM_IRQ, VEC_BASE, NMI_VEC)
//  - id_width(): width of an irq index, never less than 1 bit
package intc_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_INSERV = 2'd2
  } intc_state_e;

  localparam int DEF_NUM_IRQ  = 8;
  localparam int DEF_VEC_BASE = 28;
  localparam int DEF_NMI_VEC  = 27;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Purely combinational priority encoder: lowest set index wins.
// Ports:
//  i_vec    in  N     request vector
//  o_valid  out 1     any bit of i_vec set
//  o_id     out ID_W  index of lowest set bit (0 when none)
module intc_prio_enc
  import intc_defs_pkg::*;
#(
  parameter int N    = DEF_NUM_IRQ,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    i_vec,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id
);

  // w_seen[k] = some bit below index k is set; only the first set bit
  // survives into the one-hot vector.
  logic [N:0]   w_seen;
  logic [N-1:0] w_onehot;

  assign w_seen[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chain
      assign w_seen[gi+1] = w_seen[gi] | i_vec[gi];
      assign w_onehot[gi] = i_vec[gi] & ~w_seen[gi];
    end
  endgenerate

  assign o_valid = w_seen[N];

  always_comb begin
    o_id = '0;
    for (int i = 0; i < N; i++) begin
      if (w_onehot[i]) o_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Programmable interrupt controller in front of the cpu: latches, masks and
// prioritises NUM_IRQ maskable requests plus one NMI, and runs the
// request / ack / end-of-interrupt handshake with one ISR in service at a time.
// Build option: define IRQ_EDGE_EN for edge-triggered irq_in (default: level).
// Ports:
//  clk, rst_n              clock, asynchronous active-low reset
//  irq_in[NUM_IRQ]         device requests (0 = highest priority)
//  nmi_in                  non-maskable source (always edge-triggered)
//  int_disable             global mask from cpu
//  mask_we, mask_wdata     mask register write (bit=1 blocks the irq)
//  int_ack, nmi_ack, eoi   cpu handshake pulses
//  int_req, nmi_req        request lines to cpu
//  int_vector, nmi_vector  vector addresses
//  pending, in_service     status
module interrupt_controller
  import intc_defs_pkg::*;
#(
  parameter int NUM_IRQ  = DEF_NUM_IRQ,
  parameter int VEC_BASE = DEF_VEC_BASE,
  parameter int NMI_VEC  = DEF_NMI_VEC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  input  logic               int_disable,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               nmi_ack,
  input  logic               eoi,
  output logic               int_req,
  output logic               nmi_req,
  output logic [31:0]        int_vector,
  output logic [31:0]        nmi_vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service
);

  localparam int ID_W = id_width(NUM_IRQ);

  intc_state_e        r_state, w_state_next;
  logic [ID_W-1:0]    r_active_id, w_active_id_next;
  logic [NUM_IRQ-1:0] r_pending, r_mask, r_in_service;
  logic [NUM_IRQ-1:0] w_in_service_next, w_pend_clr, w_irq_set;
  logic [NUM_IRQ-1:0] w_eligible, w_active_onehot;
  logic               w_win_valid;
  logic [ID_W-1:0]    w_win_id;
  logic               r_nmi_d, r_nmi_req;

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] r_irq_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq_d <= '0;
    else        r_irq_d <= irq_in;
  end

  assign w_irq_set = irq_in & ~r_irq_d;
`else
  assign w_irq_set = irq_in;
`endif

  assign w_eligible = r_pending & ~r_mask & ~r_in_service;

  intc_prio_enc #(.N(NUM_IRQ), .ID_W(ID_W)) u_prio (
    .i_vec   (w_eligible),
    .o_valid (w_win_valid),
    .o_id    (w_win_id)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_onehot
      assign w_active_onehot[gi] = (r_active_id == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    w_state_next      = r_state;
    w_active_id_next  = r_active_id;
    w_pend_clr        = '0;
    w_in_service_next = r_in_service;
    case (r_state)
      ST_IDLE: begin
        if (w_win_valid && !int_disable) begin
          w_active_id_next = w_win_id;
          w_state_next     = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack in the same cycle as a withdrawal wins: the cpu already took it.
        if (int_ack) begin
          w_pend_clr        = w_active_onehot;
          w_in_service_next = w_active_onehot;
          w_state_next      = ST_INSERV;
        end else if (int_disable || |(r_mask & w_active_onehot)) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_INSERV: begin
        if (eoi) begin
          w_in_service_next = '0;
          w_state_next      = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_active_id  <= '0;
      r_pending    <= '0;
      r_mask       <= '0;
      r_in_service <= '0;
      r_nmi_d      <= 1'b0;
      r_nmi_req    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_active_id  <= w_active_id_next;
      // New request beats the ack clear, so a level line still high re-pends.
      r_pending    <= (r_pending & ~w_pend_clr) | w_irq_set;
      r_in_service <= w_in_service_next;
      if (mask_we) r_mask <= mask_wdata;
      r_nmi_d      <= nmi_in;
      r_nmi_req    <= (nmi_in & ~r_nmi_d) | (r_nmi_req & ~nmi_ack);
    end
  end

  // NMI has precedence on the cpu side; the FSM just waits in REQ meanwhile.
  assign int_req    = (r_state == ST_REQ) && !r_nmi_req;
  assign nmi_req    = r_nmi_req;
  assign int_vector = (r_state != ST_IDLE) ? (32'(VEC_BASE) + 32'(r_active_id)) : 32'd0;
  assign nmi_vector = 32'(NMI_VEC);
  assign pending    = r_pending;
  assign in_service = r_in_service;

endmodule
